// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared widths, frame defaults, sample type, FSM states and signed max
package conv_pkg;

    localparam int DATA_W    = 22;
    localparam int IMG_W_DEF = 30;
    localparam int IMG_H_DEF = 30;

    typedef logic signed [DATA_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ties may return either operand; they are equal.
    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - half-width row buffer holding horizontal maxima of the even row
// Ports:
//   clk   - clock, rising edge
//   we    - write enable
//   addr  - shared write/read address (col >> 1)
//   wdata - horizontal maximum to store
//   rdata - combinational read of entry addr
module pool_line_buf #(
    parameter int DEPTH  = 15,
    parameter int DATA_W = 22,
    parameter int AW     = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            addr,
    input  logic signed [DATA_W-1:0] wdata,
    output logic signed [DATA_W-1:0] rdata
);

    // No reset: every entry is rewritten on an even row before the odd row reads it.
    logic signed [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/max_pool_2x2.sv
// rtl/max_pool_2x2.sv - streaming 2x2 stride-2 signed max pooling, no backpressure
// Ports:
//   clk          - clock, rising edge
//   rst          - asynchronous active-high reset
//   start_signal - one-cycle frame start pulse (honoured only in IDLE)
//   in_valid     - in_data valid (accepted only in RUN)
//   in_data      - signed raster-order input sample
//   out_data     - registered signed window maximum
//   out_valid    - one-cycle pulse per pooled output
//   done_signal  - one-cycle pulse coincident with the final out_valid
module max_pool_2x2 #(
    parameter int IMG_W  = 30,
    parameter int IMG_H  = 30,
    parameter int DATA_W = 22
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_signal,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_valid,
    output logic                     done_signal
);

    import conv_pkg::*;

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam int AW    = COL_W - 1;
    localparam int N_OUT = (IMG_W / 2) * (IMG_H / 2);
    localparam int OCW   = $clog2(N_OUT + 1);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
    localparam logic [OCW-1:0]   OUT_TOTAL = OCW'(N_OUT);

    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0) begin : g_bad_dims
        $error("max_pool_2x2: IMG_W and IMG_H must both be even");
    end

    state_t           state;
    state_t           state_nxt;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [OCW-1:0]   out_cnt;
    sample_t          h_reg;
    sample_t          hmax;
    sample_t          buf_rd;
    logic             accept;
    logic             last_sample;
    logic             buf_we;

    assign accept      = (state == RUN) && in_valid;
    assign last_sample = accept && (col == COL_LAST) && (row == ROW_LAST);
    assign hmax        = smax(h_reg, in_data);
    // Even row, odd column: park the horizontal max for the row below.
    assign buf_we      = accept && col[0] && !row[0];
    assign done_signal = (state == DONE);

    pool_line_buf #(
        .DEPTH  (IMG_W / 2),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (buf_we),
        .addr  (col[COL_W-1:1]),
        .wdata (hmax),
        .rdata (buf_rd)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_signal) state_nxt = RUN;
            RUN:     if (last_sample)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            out_cnt   <= '0;
            h_reg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if ((state == IDLE) && start_signal) begin
                col     <= '0;
                row     <= '0;
                out_cnt <= '0;
                h_reg   <= '0;
            end else if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end

                if (!col[0]) begin
                    h_reg <= in_data;
                end else if (row[0]) begin
                    out_data  <= smax(buf_rd, hmax);
                    out_valid <= 1'b1;
                    out_cnt   <= out_cnt + 1'b1;
                end
            end
        end
    end

    // Entering DONE implies a full frame, so every window must have been emitted.
    always @(posedge clk) begin
        if (!rst && state == DONE) begin
            assert (out_cnt == OUT_TOTAL);
        end
    end

endmodule

// File: tb/tb_max_pool_2x2.sv
// tb/tb_max_pool_2x2.sv - directed self-checking bench for max_pool_2x2
module tb_max_pool_2x2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_signal = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [21:0] in_data = '0;
    logic signed [21:0] out_data;
    logic               out_valid;
    logic               done_signal;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int q[$];
    int q_cyc[$];
    int exp_cyc[$];
    int done_cnt = 0;
    int done_cyc = -1;

    max_pool_2x2 dut (
        .clk          (clk),
        .rst          (rst),
        .start_signal (start_signal),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .done_signal  (done_signal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                q.push_back(int'(out_data));
                q_cyc.push_back(cyc);
            end
            if (done_signal) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int sample_val(input int mode, input int r, input int c);
        int i, j, p;
        i = r / 2;
        j = c / 2;
        p = (r % 2) * 2 + (c % 2);
        case (mode)
            0: return r * 30 + c;
            1: return -(r * 30 + c);
            default: begin
                if (i == 7 && j == 3) begin
                    case (p)
                        0:       return -(1 << 21);
                        1:       return (1 << 21) - 1;
                        2:       return 0;
                        default: return -1;
                    endcase
                end
                return (p == ((i * 15 + j) % 4)) ? -1 : -5;
            end
        endcase
    endfunction

    function automatic int exp_out(input int mode, input int i, input int j);
        case (mode)
            0: return (2 * i + 1) * 30 + 2 * j + 1;
            1: return -((2 * i) * 30 + 2 * j);
            default: return (i == 7 && j == 3) ? (1 << 21) - 1 : -1;
        endcase
    endfunction

    task automatic clear_obs();
        q.delete();
        q_cyc.delete();
        exp_cyc.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic send_start(input logic with_valid);
        start_signal = 1'b1;
        in_valid     = with_valid;
        in_data      = 22'sd12345;
        step();
        start_signal = 1'b0;
        in_valid     = 1'b0;
    endtask

    task automatic drive_frame(input int mode, input int idle_pct, input int n_samples,
                               input int mid_start_at);
        int n = 0;
        for (int r = 0; r < 30; r++) begin
            for (int c = 0; c < 30; c++) begin
                if (n < n_samples) begin
                    while (int'($urandom_range(99)) < idle_pct) begin
                        in_valid     = 1'b0;
                        start_signal = 1'b0;
                        step();
                    end
                    in_valid     = 1'b1;
                    in_data      = 22'(sample_val(mode, r, c));
                    start_signal = (n == mid_start_at);
                    if ((r % 2) == 1 && (c % 2) == 1) exp_cyc.push_back(cyc + 1);
                    step();
                    n++;
                end
            end
        end
        in_valid     = 1'b0;
        start_signal = 1'b0;
    endtask

    task automatic check_frame(input string name, input int mode, input int base);
        for (int k = 0; k < 225; k++) begin
            if (base + k < q.size()) begin
                chk($sformatf("%s val[%0d]", name, k), q[base + k], exp_out(mode, k / 15, k % 15));
                chk($sformatf("%s lat[%0d]", name, k), q_cyc[base + k], exp_cyc[base + k]);
            end
        end
    endtask

    task automatic check_single(input string name, input int mode);
        chk({name, " count"}, q.size(), 225);
        chk({name, " done_cnt"}, done_cnt, 1);
        if (q.size() > 0) chk({name, " done_with_last"}, done_cyc, q_cyc[q.size() - 1]);
        check_frame(name, mode, 0);
        clear_obs();
    endtask

    initial begin
        // Reset values
        step();
        step();
        chk("rst out_data", int'(out_data), 0);
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst done", int'(done_signal), 0);
        rst = 1'b0;
        step();

        // Valid samples while IDLE are ignored
        for (int k = 0; k < 50; k++) begin
            in_valid = 1'b1;
            in_data  = 22'(k * 7);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("idle ignore count", q.size(), 0);
        clear_obs();

        // Ramp frame; start coincides with a valid that must be dropped
        send_start(1'b1);
        drive_frame(0, 0, 900, -1);
        repeat (3) step();
        check_single("ramp", 0);

        // Signed extremes
        send_start(1'b0);
        drive_frame(2, 0, 900, -1);
        repeat (3) step();
        check_single("extreme", 2);

        // Ramp with bubbles and a start pulse mid-RUN
        send_start(1'b0);
        drive_frame(0, 30, 900, 100);
        repeat (3) step();
        check_single("bubble", 0);

        // Reset after 400 accepted samples, landing on an odd/odd output cycle
        send_start(1'b0);
        drive_frame(0, 0, 400, -1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst out_data", int'(out_data), 0);
        chk("midrst done", int'(done_signal), 0);
        step();
        rst = 1'b0;
        clear_obs();
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_data  = 22'(k);
            step();
        end
        in_valid = 1'b0;
        step();
        chk("post rst idle count", q.size(), 0);
        clear_obs();
        send_start(1'b0);
        drive_frame(0, 0, 900, -1);
        repeat (3) step();
        check_single("after_rst", 0);

        // Back-to-back: second start in the cycle after done
        send_start(1'b0);
        drive_frame(0, 0, 900, -1);
        step();
        send_start(1'b0);
        drive_frame(1, 0, 900, -1);
        repeat (3) step();
        chk("b2b count", q.size(), 450);
        chk("b2b done_cnt", done_cnt, 2);
        if (q.size() > 0) chk("b2b done_with_last", done_cyc, q_cyc[q.size() - 1]);
        check_frame("b2b_a", 0, 0);
        check_frame("b2b_b", 1, 225);
        clear_obs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
